// File: rtl/arbiter_pkg.sv
// Shared state encoding and limits for the round-robin arbiter slice.
// Defining ARB_TIMEOUT_EN adds the DRAIN state used after an upstream timeout.
package arbiter_pkg;

    localparam int unsigned ARB_N_MAX     = 16;
    localparam int unsigned ARB_TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3
`ifdef ARB_TIMEOUT_EN
        ,
        DRAIN   = 3'd4
`endif
    } arb_state_t;

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin search: nearest set req bit strictly after
// last_winner, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_winner,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    int unsigned cand;

    always_comb begin
        any  = |req;
        idx  = '0;
        cand = 0;
        // Scan from the farthest offset down so the nearest hit overwrites last.
        for (int unsigned i = N; i >= 1; i--) begin
            cand = (32'(last_winner) + i) % N;
            if (req[IW'(cand)]) begin
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/arbiter_rr.sv
// Four-phase round-robin arbiter node with a merged upstream handshake (tree-composable).
// Defining ARB_TIMEOUT_EN adds the upstream-acknowledge timeout, timeout port and DRAIN state.
module arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         ack,
    output logic                 req_up,
    input  logic                 ack_up,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int unsigned IW = $clog2(N);

    if (N < 2 || N > ARB_N_MAX || TIMEOUT < 1 || TIMEOUT >= (1 << ARB_TIMEOUT_W)) begin : g_bad_param
        $error("arbiter_rr: parameter out of range");
    end

    arb_state_t    state, state_nx;
    logic [IW-1:0] last_winner, last_winner_nx;
    logic [IW-1:0] grant_id_nx;
    logic [N-1:0]  ack_nx;
    logic          req_up_nx;
    logic          pick_any;
    logic [IW-1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [ARB_TIMEOUT_W-1:0] WAIT_LAST = ARB_TIMEOUT_W'(TIMEOUT - 1);

    logic [ARB_TIMEOUT_W-1:0] wait_cnt, wait_cnt_nx;
    logic                     timeout_nx;
`endif

    rr_pick #(
        .N (N)
    ) u_pick (
        .req         (req),
        .last_winner (last_winner),
        .any         (pick_any),
        .idx         (pick_idx)
    );

    // Outputs are computed for the next state so every port comes straight from a flop.
    always_comb begin
        state_nx       = state;
        last_winner_nx = last_winner;
        grant_id_nx    = grant_id;
        ack_nx         = '0;
        req_up_nx      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_nx    = '0;
        timeout_nx     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_id_nx = pick_idx;
                    req_up_nx   = 1'b1;
                    state_nx    = REQ;
                end
            end
            REQ: begin
                req_up_nx = 1'b1;
                if (ack_up) begin
                    ack_nx[grant_id] = 1'b1;
                    state_nx         = GRANT;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    req_up_nx      = 1'b0;
                    timeout_nx     = 1'b1;
                    last_winner_nx = grant_id;
                    state_nx       = DRAIN;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
`endif
            end
            GRANT: begin
                ack_nx[grant_id] = 1'b1;
                req_up_nx        = 1'b1;
                if (!req[grant_id]) begin
                    req_up_nx = 1'b0;
                    state_nx  = RELEASE;
                end
            end
            RELEASE: begin
                ack_nx[grant_id] = 1'b1;
                if (!ack_up) begin
                    ack_nx         = '0;
                    last_winner_nx = grant_id;
                    state_nx       = IDLE;
                end
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
                if (!ack_up) begin
                    state_nx = IDLE;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= IW'(N - 1);
            grant_id    <= '0;
            ack         <= '0;
            req_up      <= 1'b0;
            busy        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            last_winner <= last_winner_nx;
            grant_id    <= grant_id_nx;
            ack         <= ack_nx;
            req_up      <= req_up_nx;
            busy        <= (state_nx != IDLE);
`ifdef ARB_TIMEOUT_EN
            wait_cnt    <= wait_cnt_nx;
            timeout     <= timeout_nx;
`endif
        end
    end

endmodule

// File: tb/tb_arbiter_rr.sv
// Scoreboard bench for arbiter_rr: directed flat N=4 scenarios plus a two-level N=2 tree.
// Timeout scenario is compiled only when ARB_TIMEOUT_EN is defined.
module tb_arbiter_rr;

    localparam int unsigned N = 4;
    localparam int W_UP   = 0;
    localparam int W_NOUP = 1;
    localparam int W_ACK  = 2;
    localparam int W_NOACK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic         req_up;
    logic         ack_up;
    logic [1:0]   grant_id;
    logic         busy;
`ifdef ARB_TIMEOUT_EN
    logic         timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    arbiter_rr #(
        .N       (N),
        .TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
        .req_up   (req_up),
        .ack_up   (ack_up),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

    // Two-level tree: leaves serve channels 0-1 and 2-3, root merges the leaves.
    logic [3:0] t_req = '0;
    logic [3:0] t_ack;
    logic [1:0] l_up;
    logic [1:0] r_ack;
    logic       t_up;
    logic       t_ack_up = 1'b0;
    logic       t_en = 1'b0;
    logic       l0_gid, l1_gid, r_gid, l0_busy, l1_busy, r_busy;
`ifdef ARB_TIMEOUT_EN
    logic       l0_to, l1_to, r_to;
`endif

    arbiter_rr #(.N(2)) u_leaf0 (
        .clk(clk), .rst_n(rst_n), .req(t_req[1:0]), .ack(t_ack[1:0]),
        .req_up(l_up[0]), .ack_up(r_ack[0]), .grant_id(l0_gid), .busy(l0_busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout(l0_to)
`endif
    );
    arbiter_rr #(.N(2)) u_leaf1 (
        .clk(clk), .rst_n(rst_n), .req(t_req[3:2]), .ack(t_ack[3:2]),
        .req_up(l_up[1]), .ack_up(r_ack[1]), .grant_id(l1_gid), .busy(l1_busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout(l1_to)
`endif
    );
    arbiter_rr #(.N(2)) u_root (
        .clk(clk), .rst_n(rst_n), .req(l_up), .ack(r_ack),
        .req_up(t_up), .ack_up(t_ack_up), .grant_id(r_gid), .busy(r_busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout(r_to)
`endif
    );

    // Four-phase clients that re-request as soon as their ack falls; upstream echoes one cycle late.
    always @(negedge clk) begin
        t_req    = t_en ? ~t_ack : 4'b0000;
        t_ack_up = t_up;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] a;
        logic [1:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   t_exp_q[$];
    int   t_seen = 0;

    task automatic expect_grant(input logic [3:0] a, input logic [1:0] g);
        exp_t e;
        e.a = a;
        e.g = g;
        exp_q.push_back(e);
    endtask

    // Flat monitor: each rising ack is matched against the oldest expected grant.
    logic [N-1:0] prev_ack = '0;
    always @(negedge clk) begin
        exp_t e;
        if (ack != '0 && prev_ack == '0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: ack=%b grant_id=%0d with nothing expected", ack, grant_id);
            end else begin
                e = exp_q.pop_front();
                chk("grant_ack", 32'(ack), 32'(e.a));
                chk("grant_id", 32'(grant_id), 32'(e.g));
                chk("ack_onehot", 32'($countones(ack)), 32'd1);
            end
        end
        prev_ack = ack;
    end

    // Tree monitor: channel order of rising leaf acks.
    logic [3:0] t_prev = '0;
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (t_ack[c] && !t_prev[c]) begin
                t_seen++;
                chk("tree_onehot", 32'($countones(t_ack)), 32'd1);
                if (t_exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tree_unexpected: channel %0d granted with nothing expected", c);
                end else begin
                    chk("tree_order", 32'(c), 32'(t_exp_q.pop_front()));
                end
            end
        end
        t_prev = t_ack;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cond(input int sel, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            case (sel)
                W_UP:    ok = (req_up == 1'b1);
                W_NOUP:  ok = (req_up == 1'b0);
                W_ACK:   ok = (ack != '0);
                default: ok = (ack == '0);
            endcase
            if (ok) break;
            tick();
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: wait expired, condition %0d never met", name, sel);
        end
    endtask

    // Upstream and winning client play one complete four-phase handshake.
    task automatic run_hs(input bit reraise, input string name);
        logic [N-1:0] w;
        wait_cond(W_UP, name);
        ack_up = 1'b1;
        wait_cond(W_ACK, name);
        w   = ack;
        req = req & ~w;
        wait_cond(W_NOUP, name);
        ack_up = 1'b0;
        wait_cond(W_NOACK, name);
        if (reraise) req = req | w;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        ack_up = 1'b0;
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_req_up", 32'(req_up), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef ARB_TIMEOUT_EN
        chk("rst_timeout", 32'(timeout), 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // req=1010 after reset: channel 1 wins, one-cycle latencies both ways.
        req = 4'b1010;
        expect_grant(4'b0010, 2'd1);
        tick();
        chk("a_req_up_lat", 32'(req_up), 32'h1);
        chk("a_grant_id", 32'(grant_id), 32'h1);
        chk("a_busy", 32'(busy), 32'h1);
        ack_up = 1'b1;
        tick();
        chk("a_ack_lat", 32'(ack), 32'h2);
        req = 4'b1000;
        tick();
        chk("a_release_up", 32'(req_up), 32'h0);
        chk("a_release_ack", 32'(ack), 32'h2);
        ack_up = 1'b0;
        expect_grant(4'b1000, 2'd3);
        tick();
        chk("a_idle_ack", 32'(ack), 32'h0);
        chk("a_idle_busy", 32'(busy), 32'h0);
        tick();
        chk("b_no_bubble_gid", 32'(grant_id), 32'h3);
        chk("b_no_bubble_up", 32'(req_up), 32'h1);

        // New request while busy must not disturb the current grant.
        ack_up = 1'b1;
        tick();
        req = 4'b1001;
        tick();
        chk("b_pending_gid", 32'(grant_id), 32'h3);
        chk("b_pending_ack", 32'(ack), 32'h8);
        req = 4'b0001;
        wait_cond(W_NOUP, "b_release");
        ack_up = 1'b0;
        wait_cond(W_NOACK, "b_idle");
        expect_grant(4'b0001, 2'd0);
        run_hs(1'b0, "b_pending_hs");

        // Winner withdraws before ack: GRANT then RELEASE anyway.
        req = 4'b0010;
        expect_grant(4'b0010, 2'd1);
        wait_cond(W_UP, "c_up");
        req = 4'b0000;
        tick();
        chk("c_still_busy", 32'(busy), 32'h1);
        ack_up = 1'b1;
        tick();
        chk("c_grant_ack", 32'(ack), 32'h2);
        tick();
        chk("c_release_up", 32'(req_up), 32'h0);
        chk("c_release_ack", 32'(ack), 32'h2);
        ack_up = 1'b0;
        tick();
        chk("c_idle_ack", 32'(ack), 32'h0);
        chk("c_idle_busy", 32'(busy), 32'h0);

        // Reset asserted mid-GRANT clears outputs without a clock edge.
        req = 4'b1000;
        expect_grant(4'b1000, 2'd3);
        wait_cond(W_UP, "d_up");
        ack_up = 1'b1;
        wait_cond(W_ACK, "d_ack");
        #2 rst_n = 1'b0;
        #1;
        chk("d_async_ack", 32'(ack), 32'h0);
        chk("d_async_up", 32'(req_up), 32'h0);
        chk("d_async_busy", 32'(busy), 32'h0);
        chk("d_async_gid", 32'(grant_id), 32'h0);
        req    = '0;
        ack_up = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // All requests held: strict rotation starting from channel 0.
        req = 4'b1111;
        expect_grant(4'b0001, 2'd0);
        expect_grant(4'b0010, 2'd1);
        expect_grant(4'b0100, 2'd2);
        expect_grant(4'b1000, 2'd3);
        expect_grant(4'b0001, 2'd0);
        for (int k = 0; k < 5; k++) begin
            run_hs(k < 4, "e_rotation");
        end
        req = '0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Upstream never answers: timeout pulse 8 cycles after req_up rises, no ack.
        begin
            int cyc;
            cyc = 0;
            req = 4'b0001;
            wait_cond(W_UP, "f_up");
            for (int i = 0; i < 40; i++) begin
                tick();
                cyc++;
                if (timeout) break;
            end
            chk("f_timeout_cycles", 32'(cyc), 32'd8);
            chk("f_timeout_up", 32'(req_up), 32'h0);
            chk("f_timeout_ack", 32'(ack), 32'h0);
            tick();
            req = '0;
            chk("f_timeout_pulse", 32'(timeout), 32'h0);
            chk("f_drain_idle", 32'(busy), 32'h0);
            tick();
        end
`endif

        // Tree: leaf rotation interleaved by the root gives 0,2,1,3 repeating.
        t_exp_q = '{0, 2, 1, 3, 0, 2, 1, 3};
        t_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (t_seen >= 8) break;
            tick();
        end
        chk("tree_grants_seen", 32'(t_seen >= 8), 32'h1);
        chk("flat_sb_drained", 32'(exp_q.size()), 32'h0);
        chk("tree_sb_drained", 32'(t_exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 The module SHALL have parameter N, default 4: number of downstream request channels, legal range 2..16.
REQ-002 The module SHALL have parameter TIMEOUT, default 255: upstream-acknowledge wait limit in cycles, range 1..65535, used only with ARB_TIMEOUT_EN.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req, input, N bits: per-channel four-phase requests (R1..Rn).
REQ-006 The module SHALL have port ack, output, N bits: per-channel acknowledges, at most one bit high at any time (A1..An).
REQ-007 The module SHALL have port req_up, output, 1 bit: merged request to the next arbiter level (R5-style).
REQ-008 The module SHALL have port ack_up, input, 1 bit: acknowledge from the next level (A5-style).
REQ-009 The module SHALL have port grant_id, output, $clog2(N) bits: index of the latched winner; valid while busy is high.
REQ-010 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 With ARB_TIMEOUT_EN defined, the module SHALL have port timeout, output, 1 bit: one-cycle pulse on upstream timeout.

Function
REQ-012 All outputs SHALL be registered; req, ack_up SHALL be sampled only at rising clk edges.
REQ-013 FSM states SHALL be IDLE, REQ, GRANT, RELEASE, DRAIN.
REQ-014 IDLE: if any req bit is high, winner is latched into grant_id and the state moves to REQ; req_up is high from the next cycle.
REQ-015 Winner selection SHALL be round-robin: first set req bit scanning upward from (last_winner+1) mod N, wrapping.
REQ-016 REQ: req_up=1; when ack_up=1, the state moves to GRANT and ack[grant_id]=1 from the next cycle.
REQ-017 GRANT: req_up=1, ack[grant_id]=1; when req[grant_id]=0, the state moves to RELEASE and req_up=0 from the next cycle.
REQ-018 RELEASE: ack[grant_id]=1, req_up=0; when ack_up=0, ack goes to all-zero, last_winner<=grant_id, and the state moves to IDLE.
REQ-019 Minimum handshake latency SHALL be: req rise to req_up rise 1 cycle; ack_up rise to ack rise 1 cycle.
REQ-020 Requests arriving while busy SHALL be held pending; they SHALL NOT alter grant_id or ack.
REQ-021 A winner dropping req before ack SHALL NOT abort the handshake: GRANT is entered, then RELEASE on the following cycle.
REQ-022 When all N requests are continuously high, every channel SHALL be granted exactly once per N handshakes.
REQ-023 A new arbitration SHALL start in the same cycle as IDLE is entered if requests are pending; there are no idle bubble cycles beyond the IDLE state.

Reset
REQ-024 Asserting rst_n low SHALL force state=IDLE, ack=0, req_up=0, grant_id=0, busy=0, timeout=0, and last_winner=N-1 (so channel 0 wins first).
REQ-025 Reset mid-handshake SHALL drop ack and req_up immediately, without completing the handshake; deassertion is synchronised to clk by the integrator.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined: a counter SHALL count cycles in REQ; on reaching TIMEOUT it pulses timeout, drops req_up, sets last_winner<=grant_id, and enters DRAIN; no ack is issued.
REQ-027 DRAIN: req_up=0, ack=0; when ack_up=0 the state moves to IDLE.
REQ-028 Without ARB_TIMEOUT_EN: the timeout port, counter, and DRAIN state are absent, and REQ waits indefinitely.

Structure
REQ-029 Package arbiter_pkg SHALL hold the FSM state enum typedef and the constants ARB_N_MAX=16 and ARB_TIMEOUT_W=16.
REQ-030 Combinational round-robin search SHALL be in sub-module rr_pick (inputs req and last_winner; outputs any and idx).
REQ-031 The block SHALL be tree-composable: req_up/ack_up of one instance connects to one req/ack bit of a parent instance.

Verification
REQ-032 After reset, N=4, req=4'b1010 -> grant_id=1, req_up high after 1 cycle; ack_up=1 -> ack=4'b0010 after 1 cycle.
REQ-033 N=4, req=4'b1111 held, ack_up echoing req_up with 1-cycle delay -> grant order 0,1,2,3,0.
REQ-034 Winner drops req in REQ -> GRANT then RELEASE, ack pulse ≥1 cycle, FSM returns to IDLE.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT=8, ack_up tied 0 -> timeout pulses exactly 8 cycles after req_up rise, ack never asserted.
REQ-036 rst_n low during GRANT -> ack=0 and req_up=0 asynchronously; first grant after reset goes to channel 0.
REQ-037 Two-level tree of N=2 instances, random four-phase traffic -> ack one-hot, no starvation within 4 handshakes.
